ysyx_22050039_fetch_unit: RTL and testbench

- Instruction fetch unit. It is the producer end of the decode stage's instruction interface.
- Holds the PC and issues single-outstanding read requests to instruction memory.
- Buffers returned instructions, with their PC, in a small FIFO and presents them to the decode stage via valid/ready.
- Accepts a redirect (jump/branch target) that flushes buffered and in-flight fetches.

---
 rtl/ysyx_22050039_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_ysyx_22050039_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050039_fetch_unit.sv
// Fetch unit: one outstanding imem read at a time, results queued with their PC toward decode.
// Latency: request the cycle after IDLE, inst_valid the cycle after the response; requests stall while the buffer is full.

module ysyx_22050039_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module ysyx_22050039_fetch_unit #(
  parameter int               XLEN       = 64,
  parameter int               INST_LEN   = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(64'h8000_0000),
  parameter int               FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
  output logic                misalign
);
  localparam int             CW      = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  typedef struct packed {
    logic [INST_LEN-1:0] inst;
    logic [XLEN-1:0]     pc;
  } entry_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after;
  logic            req_fire;
  logic            aligned;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head;

  assign aligned        = (pc[1:0] == 2'b00);
  assign misalign       = !aligned;
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Redirect cancels any same-cycle push or pop; the flush wins inside the buffer.
  assign push        = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign pop         = inst_valid && inst_ready && !redirect_valid;
  assign count_after = count + CW'(push) - CW'(pop);

  assign push_entry.inst = imem_resp_data;
  assign push_entry.pc   = req_pc;
  assign inst_valid      = (count != '0);
  assign inst            = head.inst;
  assign inst_pc         = head.pc;

  ysyx_22050039_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head),
    .count    (count)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE: if (aligned && (count < DEPTH_C)) state_nxt = REQ;
      REQ: begin
        if (req_fire) begin
          pc_nxt    = pc + XLEN'(4);
          state_nxt = WAIT;
        end
      end
      WAIT: if (imem_resp_valid) state_nxt = ((count_after < DEPTH_C) && aligned) ? REQ : IDLE;
      DROP: if (imem_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // An accepted-but-unanswered request must have its response swallowed in DROP.
    if (redirect_valid) begin
      pc_nxt = redirect_pc;
      case (state)
        REQ:        state_nxt = req_fire ? DROP : IDLE;
        WAIT, DROP: state_nxt = imem_resp_valid ? IDLE : DROP;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (req_fire) req_pc <= pc;
    end
  end
endmodule

// File: tb/tb_ysyx_22050039_fetch_unit.sv
// Scoreboard bench for the fetch unit: expected requests/instructions queued by the stimulus,
// compared by a negedge monitor against handshakes seen at the DUT ports.
module tb_ysyx_22050039_fetch_unit;
  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        misalign;

  int          n_chk;
  int          n_fail;
  int          n_hs;
  int          base;
  int          resp_delay;
  logic [63:0] exp_req[$];
  logic [63:0] exp_pc[$];
  logic [31:0] exp_ins[$];

  logic        pend;
  logic [63:0] paddr;
  int          cnt;

  ysyx_22050039_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .misalign        (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk_inst(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_inst(input logic [63:0] pc);
    exp_pc.push_back(pc);
    exp_ins.push_back(mk_inst(pc));
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    cyc(2);
    rst = 1'b1;
    imem_req_ready = rdy;
  endtask

  task automatic wait_hs(input int target, input string name);
    int k;
    k = 0;
    while (n_hs < target && k < 200) begin
      cyc(1);
      k++;
    end
    check(name, 64'(n_hs >= target), 64'd1);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_req.size() != 0 || exp_pc.size() != 0) && k < 200) begin
      cyc(1);
      k++;
    end
    check({name, "_req_left"}, 64'(exp_req.size()), 64'd0);
    check({name, "_inst_left"}, 64'(exp_pc.size()), 64'd0);
  endtask

  // Memory responder: accepts on valid&ready, answers resp_delay cycles later.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    pend = 1'b0;
    paddr = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mk_inst(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        pend  = 1'b1;
        paddr = imem_req_addr;
        cnt   = resp_delay - 1;
      end
    end
  end

  // Monitor: pops the scoreboard on every request and instruction handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && imem_req_valid && imem_req_ready) begin
        n_hs++;
        if (exp_req.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL req_unexpected: got addr %h, none expected", imem_req_addr);
        end else begin
          check("req_addr", imem_req_addr, exp_req.pop_front());
        end
      end
      if (rst && !redirect_valid && inst_valid && inst_ready) begin
        if (exp_pc.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL inst_unexpected: got pc %h inst %h, none expected", inst_pc, inst);
        end else begin
          check("inst_pc", inst_pc, exp_pc.pop_front());
          check("inst_data", 64'(inst), 64'(exp_ins.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0; n_hs = 0; resp_delay = 1;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    cyc(2);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_misalign", 64'(misalign), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h1234_5671;
    cyc(1);
    redirect_valid = 1'b0;
    check("rst_over_redirect", 64'(misalign), 64'd0);

    // Straight-line fetch from the reset vector.
    base = n_hs;
    exp_req.push_back(64'h8000_0000); exp_req.push_back(64'h8000_0004); exp_req.push_back(64'h8000_0008);
    expect_inst(64'h8000_0000); expect_inst(64'h8000_0004); expect_inst(64'h8000_0008);
    inst_ready = 1'b1;
    rst = 1'b1;
    cyc(1);
    check("p1_no_early_valid0", 64'(inst_valid), 64'd0);
    cyc(1);
    check("p1_no_early_valid1", 64'(inst_valid), 64'd0);
    wait_hs(base + 3, "p1_hs");
    imem_req_ready = 1'b0;
    drain("p1");

    // Decode stalled: two requests fill the buffer, then fetch halts.
    inst_ready = 1'b0;
    do_reset(1'b1);
    base = n_hs;
    exp_req.push_back(64'h8000_0000); exp_req.push_back(64'h8000_0004);
    wait_hs(base + 2, "p2_fill");
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      check("p2_full_stall", 64'(imem_req_valid), 64'd0);
      cyc(1);
    end
    check("p2_head_valid", 64'(inst_valid), 64'd1);
    check("p2_head_pc", inst_pc, 64'h8000_0000);
    exp_req.push_back(64'h8000_0008);
    expect_inst(64'h8000_0000); expect_inst(64'h8000_0004); expect_inst(64'h8000_0008);
    inst_ready = 1'b1;
    wait_hs(base + 3, "p2_resume");
    imem_req_ready = 1'b0;
    drain("p2");

    // Redirect in WAIT; the old response lands three cycles later in DROP.
    resp_delay = 4;
    do_reset(1'b1);
    base = n_hs;
    exp_req.push_back(64'h8000_0000); exp_req.push_back(64'h8000_1000);
    expect_inst(64'h8000_1000);
    wait_hs(base + 1, "p3_first");
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    cyc(1);
    redirect_valid = 1'b0;
    check("p3_flushed", 64'(inst_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("p3_drop_noreq", 64'(imem_req_valid), 64'd0);
      cyc(1);
    end
    wait_hs(base + 2, "p3_target");
    imem_req_ready = 1'b0;
    drain("p3");

    // Redirect together with the response in WAIT: straight to IDLE.
    resp_delay = 1;
    do_reset(1'b1);
    base = n_hs;
    exp_req.push_back(64'h8000_0000); exp_req.push_back(64'h8000_2000);
    expect_inst(64'h8000_2000);
    wait_hs(base + 1, "p4a_first");
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    cyc(1);
    redirect_valid = 1'b0;
    check("p4a_flushed", 64'(inst_valid), 64'd0);
    check("p4a_idle", 64'(imem_req_valid), 64'd0);
    wait_hs(base + 2, "p4a_target");
    imem_req_ready = 1'b0;
    drain("p4a");

    // Redirect while a request is held without ready: request withdrawn.
    do_reset(1'b0);
    base = n_hs;
    cyc(1);
    check("p4b_req_held", 64'(imem_req_valid), 64'd1);
    check("p4b_req_addr", imem_req_addr, 64'h8000_0000);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
    cyc(1);
    redirect_valid = 1'b0;
    check("p4b_withdrawn", 64'(imem_req_valid), 64'd0);
    exp_req.push_back(64'h8000_3000);
    expect_inst(64'h8000_3000);
    imem_req_ready = 1'b1;
    wait_hs(base + 1, "p4b_target");
    imem_req_ready = 1'b0;
    drain("p4b");

    // Misaligned redirect halts fetch and flushes; aligned redirect resumes.
    inst_ready = 1'b0;
    do_reset(1'b1);
    base = n_hs;
    exp_req.push_back(64'h8000_0000); exp_req.push_back(64'h8000_0004);
    wait_hs(base + 2, "p5_fill");
    cyc(2);
    check("p5_buffered", 64'(inst_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
    cyc(1);
    redirect_valid = 1'b0;
    check("p5_misalign_set", 64'(misalign), 64'd1);
    check("p5_flushed", 64'(inst_valid), 64'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("p5_halted", 64'(imem_req_valid), 64'd0);
      cyc(1);
    end
    exp_req.push_back(64'h8000_0010);
    expect_inst(64'h8000_0010);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0010;
    cyc(1);
    redirect_valid = 1'b0;
    check("p5_misalign_clr", 64'(misalign), 64'd0);
    wait_hs(base + 3, "p5_resume");
    imem_req_ready = 1'b0;
    drain("p5");

    // Reset while in WAIT; the response arrives in IDLE and must be ignored.
    resp_delay = 3;
    do_reset(1'b1);
    base = n_hs;
    exp_req.push_back(64'h8000_0000);
    wait_hs(base + 1, "p6_first");
    rst = 1'b0;
    imem_req_ready = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check("p6_late_ignored", 64'(inst_valid), 64'd0);
    check("p6_req_valid", 64'(imem_req_valid), 64'd1);
    check("p6_req_addr", imem_req_addr, 64'h8000_0000);
    check("p6_misalign", 64'(misalign), 64'd0);
    resp_delay = 1;
    exp_req.push_back(64'h8000_0000);
    expect_inst(64'h8000_0000);
    imem_req_ready = 1'b1;
    wait_hs(base + 2, "p6_refetch");
    imem_req_ready = 1'b0;
    drain("p6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
